// File: rtl/prefix_subtractor64_pkg.sv
// sub64_pkg: shared constants and the stage-2 slice bundle for prefix_subtractor64.
//   WIDTH         operand width (64 only)
//   HALF          slice width (WIDTH/2)
//   SUB64_LATENCY number of register stages from operand capture to output
// Optional feature macro: SUB64_FLAGS_EN adds the sign bits that the zero/ovf
// flags need to the stage-2 bundle.
package sub64_pkg;

  localparam int WIDTH         = 64;
  localparam int HALF          = WIDTH / 2;
  localparam int SUB64_LATENCY = 3;

  // Everything stage 3 needs: the low slice result plus both speculative
  // upper-slice results, so stage 3 only has to do the carry select.
  typedef struct packed {
    logic [HALF-1:0] lo_sum;
    logic            lo_c;
    logic [HALF-1:0] up_sum0;
    logic            up_c0;
    logic [HALF-1:0] up_sum1;
    logic            up_c1;
`ifdef SUB64_FLAGS_EN
    logic            a_sign;
    logic            b_sign;
`endif
    logic            valid;
  } s2_t;

endpackage

// File: rtl/prefix_subtractor64_if.sv
// prefix_subtractor64_if: operand/result bus of prefix_subtractor64.
//   in_valid/in_ready   input channel carrying A, B, bin
//   out_valid/out_ready output channel carrying DIFF, bout (and zero, ovf)
// Handshake: a beat transfers on a rising clock edge where valid & ready are
// both 1. On the output side out_valid/DIFF/bout stay stable while
// out_valid = 1 and out_ready = 0. in_ready is a combinational function of
// out_valid/out_ready, never of in_valid.
// modport master: the producer/consumer around the subtractor.
// modport slave : the subtractor itself.
// Optional feature macro: SUB64_FLAGS_EN adds zero and ovf.
interface prefix_subtractor64_if;
  import sub64_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] DIFF;
  logic             bout;
`ifdef SUB64_FLAGS_EN
  logic             zero;
  logic             ovf;
`endif

  modport master (
`ifdef SUB64_FLAGS_EN
    input  zero, ovf,
`endif
    output in_valid, A, B, bin, out_ready,
    input  in_ready, out_valid, DIFF, bout
  );

  modport slave (
`ifdef SUB64_FLAGS_EN
    output zero, ovf,
`endif
    input  in_valid, A, B, bin, out_ready,
    output in_ready, out_valid, DIFF, bout
  );

endinterface

// File: rtl/prefix_subtractor64_sub32.sv
// prefix_sub32: combinational 32-bit Kogge-Stone prefix adder slice.
//   a    32-bit addend
//   b    32-bit addend (the caller passes the already-inverted subtrahend)
//   cin  carry in
//   sum  32-bit sum a + b + cin
//   cout carry out of bit 31
module prefix_sub32
  import sub64_pkg::*;
(
  input  logic [HALF-1:0] a,
  input  logic [HALF-1:0] b,
  input  logic            cin,
  output logic [HALF-1:0] sum,
  output logic            cout
);

  localparam int LEVELS = $clog2(HALF);

  // g[k][i] is the group generate of bits [i : i-2^k+1] (clipped at bit 0);
  // after the last level g[LEVELS][i] is the carry into bit i+1.
  logic [HALF-1:0] g [0:LEVELS];
  logic [HALF-1:0] p [0:LEVELS];

  always_comb begin
    for (int k = 0; k <= LEVELS; k++) begin
      g[k] = '0;
      p[k] = '0;
    end
    g[0] = a & b;
    p[0] = a ^ b;
    // Fold cin into bit 0's generate so the prefix tree carries it for free.
    g[0][0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
    for (int k = 0; k < LEVELS; k++) begin
      for (int i = 0; i < HALF; i++) begin
        int j;
        j = (i >= (1 << k)) ? i - (1 << k) : 0;
        if (i >= (1 << k)) begin
          g[k+1][i] = g[k][i] | (p[k][i] & g[k][j]);
          p[k+1][i] = p[k][i] & p[k][j];
        end else begin
          g[k+1][i] = g[k][i];
          p[k+1][i] = p[k][i];
        end
      end
    end
  end

  assign sum  = p[0] ^ {g[LEVELS][HALF-2:0], cin};
  assign cout = g[LEVELS][HALF-1];

endmodule

// File: rtl/prefix_subtractor64.sv
// prefix_subtractor64: 3-stage pipelined 64-bit carry-select subtractor,
// DIFF = A - B - bin (mod 2^64), bout = 1 iff A < B + bin (unsigned).
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    prefix_subtractor64_if.slave: in_valid/in_ready/A/B/bin,
//          out_valid/out_ready/DIFF/bout (+ zero/ovf)
// Stages: S1 operand register (A, ~B, ~bin), S2 three 32-bit prefix slices
// (low, upper with cin=0, upper with cin=1), S3 carry select and output.
// All stages advance together when adv = ~out_valid | out_ready.
// Optional feature macro: SUB64_FLAGS_EN adds the zero and signed-overflow
// flags, computed in S3 from the final difference.
module prefix_subtractor64
  import sub64_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  prefix_subtractor64_if.slave bus
);

  logic adv;

  // Stage 1
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_nb;
  logic             s1_nbin;

  // Stage 2
  logic [HALF-1:0]  lo_sum, up_sum0, up_sum1;
  logic             lo_c, up_c0, up_c1;
  s2_t              s2_d, s2_q;

  // Stage 3
  logic [WIDTH-1:0] diff_sel;
  logic             bout_sel;
  logic             out_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
`ifdef SUB64_FLAGS_EN
  logic             zero_q;
  logic             ovf_q;
`endif

  assign adv          = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = adv;

  // S1: the subtrahend and borrow are inverted here so the rest of the
  // datapath is a plain adder. Bubbles load the data registers too; only
  // s1_valid matters for them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_nb    <= '0;
      s1_nbin  <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s1_a     <= bus.A;
      s1_nb    <= ~bus.B;
      s1_nbin  <= ~bus.bin;
    end
  end

  prefix_sub32 u_lo (
    .a    (s1_a[HALF-1:0]),
    .b    (s1_nb[HALF-1:0]),
    .cin  (s1_nbin),
    .sum  (lo_sum),
    .cout (lo_c)
  );

  prefix_sub32 u_up0 (
    .a    (s1_a[WIDTH-1:HALF]),
    .b    (s1_nb[WIDTH-1:HALF]),
    .cin  (1'b0),
    .sum  (up_sum0),
    .cout (up_c0)
  );

  prefix_sub32 u_up1 (
    .a    (s1_a[WIDTH-1:HALF]),
    .b    (s1_nb[WIDTH-1:HALF]),
    .cin  (1'b1),
    .sum  (up_sum1),
    .cout (up_c1)
  );

  always_comb begin
    s2_d         = '0;
    s2_d.lo_sum  = lo_sum;
    s2_d.lo_c    = lo_c;
    s2_d.up_sum0 = up_sum0;
    s2_d.up_c0   = up_c0;
    s2_d.up_sum1 = up_sum1;
    s2_d.up_c1   = up_c1;
`ifdef SUB64_FLAGS_EN
    s2_d.a_sign  = s1_a[WIDTH-1];
    s2_d.b_sign  = ~s1_nb[WIDTH-1];
`endif
    s2_d.valid   = s1_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_q <= '0;
    end else if (adv) begin
      s2_q <= s2_d;
    end
  end

  // S3: a low-slice carry means "no borrow out of the low half", which picks
  // the cin=1 upper copy. Borrow out is the inverse of the final carry.
  always_comb begin
    diff_sel = {(s2_q.lo_c ? s2_q.up_sum1 : s2_q.up_sum0), s2_q.lo_sum};
    bout_sel = ~(s2_q.lo_c ? s2_q.up_c1 : s2_q.up_c0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
`ifdef SUB64_FLAGS_EN
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else if (adv) begin
      out_valid_q <= s2_q.valid;
      diff_q      <= diff_sel;
      bout_q      <= bout_sel;
`ifdef SUB64_FLAGS_EN
      zero_q      <= (diff_sel == '0);
      // Overflow only when the operand signs differ and the result's sign
      // departs from the minuend's.
      ovf_q       <= (s2_q.a_sign ^ s2_q.b_sign) &
                     (diff_sel[WIDTH-1] ^ s2_q.a_sign);
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.DIFF      = diff_q;
  assign bus.bout      = bout_q;
`ifdef SUB64_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
`endif

endmodule
